// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main FSM and the MIPS datapath.
// The master side is the control FSM: it drives every strobe, mux select and
// ALUOp, and observes Opcode, Zero, MemReady and JumpReg from the datapath and
// the ALU control decoder.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       JumpReg;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, JumpReg, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );

    modport slave (
        output Opcode, JumpReg, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Only the state is
// registered; every control output is decoded combinationally from the state
// and the live datapath inputs. Write strobes are gated off while reset is
// low so that a reset mid-instruction commits nothing.
module multicycle_control #(
    parameter bit HONOR_MEM_READY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q, state_d;
    logic   mem_rdy;
    logic   en;          // low while reset is held: suppresses every strobe
    logic [2:0] imm_aluop;

    assign mem_rdy   = HONOR_MEM_READY ? bus.MemReady : 1'b1;
    assign en        = reset;
    assign bus.State = state_q;

    // ALU operation for the immediate-type instructions, shared by EXEC_I and I_WB
    always_comb begin
        imm_aluop = 3'b100;
        case (bus.Opcode)
            OP_ORI:  imm_aluop = 3'b101;
            OP_LUI:  imm_aluop = 3'b110;
            OP_ANDI: imm_aluop = 3'b010;
            default: imm_aluop = 3'b100;
        endcase
    end

    // State register: asynchronous return to FETCH on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and control output decode
    always_comb begin
        state_d       = S_FETCH;
        bus.PCWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 2'b00;
        bus.MemtoReg  = 2'b00;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 3'b000;
        bus.PCSource  = 2'b00;
        bus.IllegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = en;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 3'b100;
                bus.IRWrite = en & mem_rdy;
                bus.PCWrite = en & mem_rdy;
                state_d     = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = 3'b100;
                case (bus.Opcode)
                    OP_RTYPE:                         state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    default: begin
                        state_d       = S_FETCH;
                        bus.IllegalOp = en;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b111;
                if (bus.JumpReg) begin
                    bus.PCSource = 2'b11;
                    bus.PCWrite  = en;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                bus.RegDst   = 2'b01;
                bus.RegWrite = en;
                bus.ALUOp    = 3'b111;
                state_d      = S_FETCH;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = imm_aluop;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                bus.RegWrite = en;
                bus.ALUOp    = imm_aluop;
                state_d      = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 3'b100;
                state_d     = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.IorD    = 1'b1;
                bus.MemRead = en;
                state_d     = mem_rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = en;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = en;
                state_d      = mem_rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = 3'b001;
                bus.PCSource = 2'b01;
                bus.PCWrite  = en & ((bus.Opcode == OP_BNE) ? ~bus.Zero : bus.Zero);
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = en;
                if (bus.Opcode == OP_JAL) begin
                    // PC still holds PC+4 here, so $31 captures the return address
                    bus.RegWrite = en;
                    bus.RegDst   = 2'b10;
                    bus.MemtoReg = 2'b10;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for the multicycle main control FSM.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    multicycle_control_if ifc ();

    multicycle_control #(.HONOR_MEM_READY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        ifc.Opcode   = 6'b000000;
        ifc.JumpReg  = 1'b0;
        ifc.Zero     = 1'b0;
        ifc.MemReady = 1'b1;
        #12;
        // reset held low
        check_vec("rst_state",  8'(ifc.State),    8'd0);
        check_vec("rst_pcw",    8'(ifc.PCWrite),  8'd0);
        check_vec("rst_irw",    8'(ifc.IRWrite),  8'd0);
        check_vec("rst_regw",   8'(ifc.RegWrite), 8'd0);
        check_vec("rst_memw",   8'(ifc.MemWrite), 8'd0);
        check_vec("rst_memr",   8'(ifc.MemRead),  8'd0);
        check_vec("rst_srcb",   8'(ifc.ALUSrcB),  8'd1);
        reset = 1'b1;
        #1;
        check_vec("fetch_pcw",  8'(ifc.PCWrite),  8'd1);
        check_vec("fetch_irw",  8'(ifc.IRWrite),  8'd1);
        check_vec("fetch_aop",  8'(ifc.ALUOp),    8'd4);
        check_vec("fetch_srcb", 8'(ifc.ALUSrcB),  8'd1);
        check_vec("fetch_memr", 8'(ifc.MemRead),  8'd1);

        // R-type ADD: 0,1,6,7,0
        ifc.Opcode = 6'b000000; ifc.JumpReg = 1'b0;
        tick();
        check_vec("add_s1",    8'(ifc.State),   8'd1);
        check_vec("dec_srcb",  8'(ifc.ALUSrcB), 8'd3);
        check_vec("dec_pcw",   8'(ifc.PCWrite), 8'd0);
        tick();
        check_vec("add_s6",    8'(ifc.State),   8'd6);
        check_vec("add_aop6",  8'(ifc.ALUOp),   8'd7);
        check_vec("add_srca",  8'(ifc.ALUSrcA), 8'd1);
        tick();
        check_vec("add_s7",    8'(ifc.State),   8'd7);
        check_vec("add_aop7",  8'(ifc.ALUOp),   8'd7);
        check_vec("add_rdst",  8'(ifc.RegDst),  8'd1);
        check_vec("add_regw",  8'(ifc.RegWrite),8'd1);
        tick();
        check_vec("add_s0",    8'(ifc.State),   8'd0);
        check_vec("add_regw0", 8'(ifc.RegWrite),8'd0);

        // JR: 0,1,6,0
        ifc.JumpReg = 1'b1;
        tick();
        check_vec("jr_s1",     8'(ifc.State),   8'd1);
        tick();
        check_vec("jr_s6",     8'(ifc.State),   8'd6);
        check_vec("jr_psrc",   8'(ifc.PCSource),8'd3);
        check_vec("jr_pcw",    8'(ifc.PCWrite), 8'd1);
        check_vec("jr_regw",   8'(ifc.RegWrite),8'd0);
        tick();
        check_vec("jr_s0",     8'(ifc.State),   8'd0);
        ifc.JumpReg = 1'b0;

        // ORI then LUI
        ifc.Opcode = 6'b001101;
        tick(); tick();
        check_vec("ori_s8",    8'(ifc.State),   8'd8);
        check_vec("ori_aop",   8'(ifc.ALUOp),   8'd5);
        check_vec("ori_srcb",  8'(ifc.ALUSrcB), 8'd2);
        tick();
        check_vec("ori_s9",    8'(ifc.State),   8'd9);
        check_vec("ori_rdst",  8'(ifc.RegDst),  8'd0);
        check_vec("ori_regw",  8'(ifc.RegWrite),8'd1);
        check_vec("ori_aop9",  8'(ifc.ALUOp),   8'd5);
        tick();
        ifc.Opcode = 6'b001111;
        tick(); tick();
        check_vec("lui_aop",   8'(ifc.ALUOp),   8'd6);
        tick();
        check_vec("lui_s9",    8'(ifc.State),   8'd9);
        check_vec("lui_regw",  8'(ifc.RegWrite),8'd1);
        tick();
        check_vec("lui_s0",    8'(ifc.State),   8'd0);

        // LW with 3-cycle stall in MEM_READ
        ifc.Opcode = 6'b100011;
        tick(); tick();
        check_vec("lw_s2",     8'(ifc.State),   8'd2);
        ifc.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("lw_wait_s", 8'(ifc.State),   8'd3);
            check_vec("lw_wait_r", 8'(ifc.MemRead), 8'd1);
        end
        ifc.MemReady = 1'b1;
        #1;
        check_vec("lw_last_s", 8'(ifc.State),   8'd3);
        check_vec("lw_iord",   8'(ifc.IorD),    8'd1);
        tick();
        check_vec("lw_s4",     8'(ifc.State),   8'd4);
        check_vec("lw_m2r",    8'(ifc.MemtoReg),8'd1);
        check_vec("lw_regw",   8'(ifc.RegWrite),8'd1);
        tick();
        check_vec("lw_s0",     8'(ifc.State),   8'd0);

        // SW with the same stall
        ifc.Opcode = 6'b101011;
        tick(); tick();
        ifc.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("sw_wait_s", 8'(ifc.State),    8'd5);
            check_vec("sw_wait_w", 8'(ifc.MemWrite), 8'd1);
        end
        ifc.MemReady = 1'b1;
        #1;
        check_vec("sw_last_w", 8'(ifc.MemWrite), 8'd1);
        tick();
        check_vec("sw_s0",     8'(ifc.State),    8'd0);
        check_vec("sw_memw0",  8'(ifc.MemWrite), 8'd0);

        // FETCH stall: no PC/IR update while memory is busy
        ifc.MemReady = 1'b0;
        #1;
        check_vec("fst_pcw",   8'(ifc.PCWrite), 8'd0);
        check_vec("fst_irw",   8'(ifc.IRWrite), 8'd0);
        tick();
        check_vec("fst_s0",    8'(ifc.State),   8'd0);
        ifc.MemReady = 1'b1;

        // BEQ taken, BNE not taken (Zero = 1)
        ifc.Opcode = 6'b000100; ifc.Zero = 1'b1;
        tick(); tick();
        check_vec("beq_s10",   8'(ifc.State),   8'd10);
        check_vec("beq_pcw",   8'(ifc.PCWrite), 8'd1);
        check_vec("beq_psrc",  8'(ifc.PCSource),8'd1);
        check_vec("beq_aop",   8'(ifc.ALUOp),   8'd1);
        tick();
        ifc.Opcode = 6'b000101;
        tick(); tick();
        check_vec("bne_s10",   8'(ifc.State),   8'd10);
        check_vec("bne_pcw",   8'(ifc.PCWrite), 8'd0);
        tick();
        check_vec("bne_s0",    8'(ifc.State),   8'd0);
        ifc.Zero = 1'b0;

        // JAL
        ifc.Opcode = 6'b000011;
        tick(); tick();
        check_vec("jal_s11",   8'(ifc.State),   8'd11);
        check_vec("jal_pcw",   8'(ifc.PCWrite), 8'd1);
        check_vec("jal_psrc",  8'(ifc.PCSource),8'd2);
        check_vec("jal_regw",  8'(ifc.RegWrite),8'd1);
        check_vec("jal_rdst",  8'(ifc.RegDst),  8'd2);
        check_vec("jal_m2r",   8'(ifc.MemtoReg),8'd2);
        tick();

        // J: no link write
        ifc.Opcode = 6'b000010;
        tick(); tick();
        check_vec("j_s11",     8'(ifc.State),   8'd11);
        check_vec("j_regw",    8'(ifc.RegWrite),8'd0);
        tick();

        // illegal opcode
        ifc.Opcode = 6'b111111;
        tick();
        check_vec("ill_s1",    8'(ifc.State),    8'd1);
        check_vec("ill_pulse", 8'(ifc.IllegalOp),8'd1);
        tick();
        check_vec("ill_s0",    8'(ifc.State),    8'd0);
        check_vec("ill_clr",   8'(ifc.IllegalOp),8'd0);

        // reset during MEM_WB aborts the load writeback
        ifc.Opcode = 6'b100011;
        tick(); tick(); tick(); tick();
        check_vec("abt_s4",    8'(ifc.State),   8'd4);
        check_vec("abt_regw1", 8'(ifc.RegWrite),8'd1);
        reset = 1'b0;
        #1;
        check_vec("abt_regw0", 8'(ifc.RegWrite),8'd0);
        check_vec("abt_s0",    8'(ifc.State),   8'd0);
        tick();
        reset = 1'b1;
        tick();
        check_vec("abt_rel_s1", 8'(ifc.State),  8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
